// File: rtl/counter_pkg.sv
// Shared types and constants for the small binary counters built on d_flipflop.
package counter_pkg;

  typedef logic [3:0] count_t;

  localparam count_t COUNT_MAX = 4'hF;
  localparam count_t COUNT_MIN = 4'h0;

  // Modulo-16 step; wrap-around falls out of the 4-bit result width.
  function automatic count_t count_step(input count_t value, input logic up);
    count_t result;
    result = up ? (value + 4'd1) : (value - 4'd1);
    return result;
  endfunction

endpackage

// File: rtl/d_flipflop.sv
// Single-bit D flip-flop with asynchronous active-low clear; the shared storage primitive.
module d_flipflop (
  input  logic clock,
  input  logic reset,
  input  logic data_in,
  output logic data_out
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out <= 1'b0;
    end else begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/bit_counter4.sv
// 4-bit up/down counter with parallel load, stored in four d_flipflop instances.
module bit_counter4
  import counter_pkg::*;
#(
  parameter count_t RESET_VALUE        = 4'b0000,
  parameter bit     COUNT_DOWN_DEFAULT = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       up_down,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       bit_1,
  output logic       bit_2,
  output logic       bit_3,
  output logic       bit_4,
  output logic [3:0] count,
  output logic       terminal
);

  count_t count_next;
  count_t ff_d;
  count_t ff_q;

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_value;
    end else if (enable) begin
      count_next = count_step(count, up_down);
    end
  end

  // The primitive always clears to 0, so bits whose reset value is 1 are
  // stored inverted; the flop then clears straight to RESET_VALUE.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign ff_d[gi]  = count_next[gi] ^ RESET_VALUE[gi];
      assign count[gi] = ff_q[gi] ^ RESET_VALUE[gi];

      d_flipflop u_ff (
        .clock   (clock),
        .reset   (reset),
        .data_in (ff_d[gi]),
        .data_out(ff_q[gi])
      );
    end

    // Idle direction is descriptive only; it leaves a marker scope in the hierarchy.
    if (COUNT_DOWN_DEFAULT) begin : g_idle_down
    end else begin : g_idle_up
    end
  endgenerate

  assign bit_1 = count[0];
  assign bit_2 = count[1];
  assign bit_3 = count[2];
  assign bit_4 = count[3];

  assign terminal = enable & ((up_down & (count == COUNT_MAX)) |
                              (~up_down & (count == COUNT_MIN)));

endmodule

// File: tb/tb_bit_counter4.sv
// Directed bench for bit_counter4 and a standalone d_flipflop, scoreboard-checked.
module tb_bit_counter4;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [3:0] load_value;
  logic       bit_1, bit_2, bit_3, bit_4;
  logic [3:0] count;
  logic       terminal;

  logic       ff_d;
  logic       ff_q;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] model;
  logic [3:0] exp_q[$];
  logic       ff_exp_q[$];
  bit         done = 0;

  bit_counter4 dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .up_down   (up_down),
    .load      (load),
    .load_value(load_value),
    .bit_1     (bit_1),
    .bit_2     (bit_2),
    .bit_3     (bit_3),
    .bit_4     (bit_4),
    .count     (count),
    .terminal  (terminal)
  );

  d_flipflop u_ff (
    .clock   (clock),
    .reset   (reset),
    .data_in (ff_d),
    .data_out(ff_q)
  );

  // Period 10, rising edges at 10, 20, 30, ...
  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  // data_in toggles on odd times so it never coincides with an edge.
  initial begin
    ff_d = 1'b0;
    #1;
    forever #2 ff_d = ~ff_d;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_terminal(input logic [3:0] c, input logic en, input logic ud);
    return en & ((ud & (c == 4'hF)) | (~ud & (c == 4'h0)));
  endfunction

  // Called at a point 1 unit after a rising edge; returns at the same phase one edge later.
  task automatic step(input logic en, input logic ud, input logic ld, input logic [3:0] lv);
    logic [3:0] e;
    enable = en; up_down = ud; load = ld; load_value = lv;
    #1;
    check("terminal", {3'b0, terminal}, {3'b0, exp_terminal(model, en, ud)});
    if (ld) model = lv;
    else if (en) model = ud ? model + 4'd1 : model - 4'd1;
    exp_q.push_back(model);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("count", count, e);
    check("bits", {bit_4, bit_3, bit_2, bit_1}, e);
    $display("[TB] t=%0t en=%0b ud=%0b ld=%0b lv=%h -> count=%h", $time, en, ud, ld, lv, count);
  endtask

  // Standalone flop: expected value is data_in as sampled at each edge, 0 in reset.
  initial begin
    logic e;
    while (!done) begin
      @(posedge clock);
      ff_exp_q.push_back(reset ? ff_d : 1'b0);
      #1;
      if (!done) begin
        e = ff_exp_q.pop_front();
        check("dff", {3'b0, ff_q}, {3'b0, e});
      end
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b1; up_down = 1'b1; load = 1'b0; load_value = 4'h0;
    model = 4'h0;

    // Reset held to t=15 with enable active; edge at 10 must be ignored.
    #1;  check("rst_t1", count, 4'h0);
    #10; check("rst_t11", count, 4'h0);
    check("rst_bits", {bit_4, bit_3, bit_2, bit_1}, 4'h0);
    #3;  check("rst_t14", count, 4'h0);
    #1;  reset = 1'b1;
    #4;  check("rel_t19", count, 4'h0);
    @(posedge clock); #1;
    check("first_edge", count, 4'h1);
    model = 4'h1;

    // Up count from 0 over 17 edges, wrapping through 15 -> 0.
    step(1'b0, 1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, 4'h0);

    // Down count from 0: 15, 14, 13.
    step(1'b0, 1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'h0);

    // Load wins over enable, then hold.
    step(1'b0, 1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b1, 1'b1, 4'hA);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'h0);

    // Terminal must stay low at the extremes when counting the other way.
    step(1'b0, 1'b1, 1'b1, 4'hF);
    step(1'b1, 1'b0, 1'b0, 4'h0);

    // Asynchronous reset mid-count at 9; load/enable during reset are ignored.
    step(1'b0, 1'b1, 1'b1, 4'h9);
    enable = 1'b1; up_down = 1'b1; load = 1'b1; load_value = 4'h7;
    #2; reset = 1'b0;
    #1; check("async_clr", count, 4'h0);
    @(posedge clock); #1;
    check("rst_ign_load", count, 4'h0);
    load = 1'b0;
    #2; reset = 1'b1;
    @(posedge clock); #1;
    check("resume_1", count, 4'h1);
    model = 4'h1;
    step(1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 4'h0);

    check("sb_empty", 4'(exp_q.size()), 4'h0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
